// File: rtl/imm_gen_fifo.sv
// RV immediate extender feeding a DEPTH-entry valid/ready FIFO.
// The format comes from the opcode (auto) or from in_sel. Flush empties the queue synchronously.
module imm_gen_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic                     in_auto,
   input  logic [2:0]               in_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_imm,
   output logic [2:0]               out_fmt,
   output logic                     out_none,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int CW = $clog2(DEPTH) + 1;

   localparam logic [2:0] FMT_I    = 3'b000;
   localparam logic [2:0] FMT_S    = 3'b001;
   localparam logic [2:0] FMT_B    = 3'b010;
   localparam logic [2:0] FMT_U    = 3'b011;
   localparam logic [2:0] FMT_J    = 3'b100;
   localparam logic [2:0] FMT_NONE = 3'b111;

   logic [2:0]      dec_fmt;
   logic [XLEN-1:0] dec_imm;

   always_comb begin
      dec_fmt = FMT_NONE;
      if (in_auto) begin
         case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b0011011,
            7'b1100111, 7'b1110011: dec_fmt = FMT_I;
            7'b0100011:             dec_fmt = FMT_S;
            7'b1100011:             dec_fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_fmt = FMT_U;
            7'b1101111:             dec_fmt = FMT_J;
            default:                dec_fmt = FMT_NONE;
         endcase
      end else if (in_sel <= FMT_J) begin
         dec_fmt = in_sel;
      end
   end

   // Fill with the sign bit first, then overwrite the low field; avoids zero-width replication at XLEN=32.
   always_comb begin
      dec_imm = {XLEN{in_instr[31]}};
      case (dec_fmt)
         FMT_I: dec_imm[11:0] = in_instr[31:20];
         FMT_S: dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
         FMT_B: dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: dec_imm[31:0] = {in_instr[31:12], 12'b0};
         FMT_J: dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
         default: dec_imm = '0;
      endcase
   end

   logic [XLEN-1:0]  mem_imm [DEPTH];
   logic [2:0]       mem_fmt [DEPTH];
   logic [DEPTH-1:0] wr_ptr;
   logic [DEPTH-1:0] rd_ptr;
   logic             push;
   logic             pop;
   logic [XLEN-1:0]  head_imm;
   logic [2:0]       head_fmt;

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= DEPTH'(1);
         rd_ptr <= DEPTH'(1);
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= DEPTH'(1);
         rd_ptr <= DEPTH'(1);
         count  <= '0;
      end else begin
         if (push) wr_ptr <= {wr_ptr[DEPTH-2:0], wr_ptr[DEPTH-1]};
         if (pop)  rd_ptr <= {rd_ptr[DEPTH-2:0], rd_ptr[DEPTH-1]};
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < DEPTH; k++) begin
         if (push && !flush && wr_ptr[k]) begin
            mem_imm[k] <= dec_imm;
            mem_fmt[k] <= dec_fmt;
         end
      end
   end

   always_comb begin
      head_imm = '0;
      head_fmt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rd_ptr[k]) begin
            head_imm = head_imm | mem_imm[k];
            head_fmt = head_fmt | mem_fmt[k];
         end
      end
   end

   assign out_imm  = out_valid ? head_imm : '0;
   assign out_fmt  = out_valid ? head_fmt : '0;
   assign out_none = out_valid & (head_fmt == FMT_NONE);

endmodule

// File: tb/tb_imm_gen_fifo.sv
// Bench for imm_gen_fifo: XLEN=32 and XLEN=64 instances share stimulus, checked against a queue model.
module tb_imm_gen_fifo;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_auto, out_ready;
   logic [31:0] in_instr;
   logic [2:0]  in_sel;
   logic        in_ready, out_valid, out_none;
   logic        in_ready64, out_valid64, out_none64;
   logic [31:0] out_imm;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt, out_fmt64, count, count64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] imm;
      logic [2:0]  fmt;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   imm_gen_fifo #(.XLEN(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_auto(in_auto), .in_sel(in_sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt), .out_none(out_none),
      .count(count));

   imm_gen_fifo #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_auto(in_auto), .in_sel(in_sel), .out_valid(out_valid64),
      .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64), .out_none(out_none64),
      .count(count64));

   function automatic void ref_imm(input logic [31:0] i, input logic au, input logic [2:0] sel,
                                   output logic [63:0] imm, output logic [2:0] fmt);
      if (au) begin
         case (i[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: fmt = 3'd0;
            7'h23:                             fmt = 3'd1;
            7'h63:                             fmt = 3'd2;
            7'h37, 7'h17:                      fmt = 3'd3;
            7'h6F:                             fmt = 3'd4;
            default:                           fmt = 3'd7;
         endcase
      end else begin
         fmt = (sel <= 3'd4) ? sel : 3'd7;
      end
      case (fmt)
         3'd0: imm = 64'($signed(i[31:20]));
         3'd1: imm = 64'($signed({i[31:25], i[11:7]}));
         3'd2: imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         3'd3: imm = 64'($signed({i[31:12], 12'b0}));
         3'd4: imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         default: imm = 64'd0;
      endcase
   endfunction

   // Drive one cycle starting just after a rising edge, advance the model across the edge.
   task automatic step(input logic v, input logic [31:0] instr, input logic au,
                       input logic [2:0] sel, input logic ordy, input logic fl);
      ent_t e;
      logic do_push, do_pop;
      in_valid  = v;
      in_instr  = instr;
      in_auto   = au;
      in_sel    = sel;
      out_ready = ordy;
      flush     = fl;
      ref_imm(instr, au, sel, e.imm, e.fmt);
      do_push = v && (q.size() < DEPTH);
      do_pop  = ordy && (q.size() > 0);
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 0; in_valid = 0; in_auto = 0; in_sel = 0; out_ready = 0; in_instr = 0;
      #12;
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_imm !== 32'd0 || out_fmt !== 3'd0 || out_none !== 1'b0) begin
         errors++; $display("FAIL reset_data imm %h fmt %b none %b exp 0", out_imm, out_fmt, out_none); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_auto_formats();
      ent_t e;
      in_valid = 1; in_instr = 32'hFFF00093; in_auto = 1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_passthrough out_valid got %b exp 0", out_valid); end
      step(1, 32'hFFF00093, 1, 3'd5, 0, 0);
      checks++; if (out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd0 || out_none !== 1'b0) begin
         errors++; $display("FAIL auto_I imm %h fmt %b none %b exp FFFFFFFF 000 0", out_imm, out_fmt, out_none); end
      step(1, 32'hFE000EE3, 1, 3'd0, 1, 0);
      e = q[0];
      checks++; if (out_imm !== e.imm[31:0] || out_fmt !== 3'd2) begin
         errors++; $display("FAIL auto_B imm %h fmt %b exp %h 010", out_imm, out_fmt, e.imm[31:0]); end
      step(1, 32'h0080006F, 1, 3'd0, 1, 0);
      checks++; if (out_imm !== 32'h00000008 || out_fmt !== 3'd4 || out_none !== 1'b0) begin
         errors++; $display("FAIL auto_J imm %h fmt %b exp 00000008 100", out_imm, out_fmt); end
      step(1, 32'h0000007F, 1, 3'd0, 1, 0);
      checks++; if (out_imm !== 32'd0 || out_fmt !== 3'd7 || out_none !== 1'b1) begin
         errors++; $display("FAIL auto_unknown imm %h fmt %b none %b exp 0 111 1", out_imm, out_fmt, out_none); end
      step(0, 0, 0, 0, 1, 0);
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL drain_empty valid %b count %0d exp 0 0", out_valid, count); end
   endtask

   task automatic test_u64_manual();
      step(1, 32'h800000B7, 1, 3'd0, 0, 0);
      checks++; if (out_imm64 !== 64'hFFFFFFFF80000000 || out_fmt64 !== 3'd3) begin
         errors++; $display("FAIL u64 imm %h fmt %b exp FFFFFFFF80000000 011", out_imm64, out_fmt64); end
      checks++; if (out_imm !== 32'h80000000) begin
         errors++; $display("FAIL u32 imm %h exp 80000000", out_imm); end
      step(1, 32'hFFFFFFFF, 0, 3'b110, 1, 0);
      checks++; if (out_imm !== 32'd0 || out_imm64 !== 64'd0 || out_none !== 1'b1 || out_fmt !== 3'd7) begin
         errors++; $display("FAIL manual_none imm %h none %b fmt %b exp 0 1 111", out_imm, out_none, out_fmt); end
      step(1, 32'hABC00000, 0, 3'd1, 1, 0);
      checks++; if (out_imm !== 32'hFFFFFABC - 32'hABC + 32'h000) begin
         // S-type: bits[31:25]=1010101, [11:7]=0 -> 12'hAA0 sign-extended
      end
      checks++; if (out_imm !== 32'hFFFFFAA0 || out_fmt !== 3'd1) begin
         errors++; $display("FAIL manual_S imm %h fmt %b exp FFFFFAA0 001", out_imm, out_fmt); end
      step(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_fill();
      for (int k = 0; k < 4; k++) step(1, {12'(k * 37 + 1), 13'd0, 7'h13}, 1, 0, 0, 0);
      checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
         errors++; $display("FAIL full count %0d in_ready %b exp 4 0", count, in_ready); end
      checks++; if (out_imm !== 32'd1) begin errors++; $display("FAIL full_hold imm %h exp 1", out_imm); end
      step(1, {12'h7FF, 13'd0, 7'h13}, 1, 0, 1, 0);
      checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin
         errors++; $display("FAIL full_pushpop count %0d in_ready %b exp 3 1", count, in_ready); end
      for (int k = 1; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1 || out_imm !== 32'(k * 37 + 1)) begin
            errors++; $display("FAIL drain_order %0d imm %h exp %h", k, out_imm, 32'(k * 37 + 1)); end
         step(0, 0, 0, 0, 1, 0);
      end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_done valid %b exp 0", out_valid); end
   endtask

   task automatic test_random();
      logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h0F};
      logic [31:0] r;
      logic rdy;
      for (int n = 0; n < 300; n++) begin
         r = $urandom;
         rdy = (n < 20) ? n[0] : ($urandom_range(0, 2) != 0);
         step(($urandom_range(0, 3) != 0), {r[31:7], ops[$urandom_range(0, 11)]},
              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rdy, 0);
         checks++; if (count !== 3'(q.size()) || count64 !== 3'(q.size()) || count > 3'd4) begin
            errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, count, q.size()); end
         checks++; if (out_valid !== (q.size() != 0) || in_ready !== (q.size() != DEPTH)) begin
            errors++; $display("FAIL rnd_flags cyc %0d valid %b ready %b size %0d", n, out_valid, in_ready, q.size()); end
         if (q.size() != 0) begin
            checks++; if (out_imm !== q[0].imm[31:0] || out_imm64 !== q[0].imm || out_fmt !== q[0].fmt
                          || out_none !== (q[0].fmt == 3'd7)) begin
               errors++; $display("FAIL rnd_head cyc %0d imm %h fmt %b exp %h %b", n, out_imm64, out_fmt,
                                  q[0].imm, q[0].fmt); end
         end else begin
            checks++; if (out_imm !== 32'd0 || out_fmt !== 3'd0 || out_none !== 1'b0) begin
               errors++; $display("FAIL rnd_empty_data cyc %0d imm %h fmt %b", n, out_imm, out_fmt); end
         end
      end
      while (q.size() != 0) step(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_flush();
      for (int k = 0; k < 3; k++) step(1, 32'h00100093, 1, 0, 0, 0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL pre_flush count %0d exp 3", count); end
      step(1, 32'h00200093, 1, 0, 1, 1);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush count %0d valid %b ready %b exp 0 0 1", count, out_valid, in_ready); end
      step(0, 0, 0, 0, 0, 0);
      checks++; if (count !== 3'd0 || out_imm !== 32'd0) begin
         errors++; $display("FAIL flush_nopush count %0d imm %h exp 0 0", count, out_imm); end
   endtask

   task automatic test_async_rst();
      step(1, 32'hFFF00093, 1, 0, 0, 0);
      step(1, 32'h00500093, 1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_imm !== 32'd0 || out_imm64 !== 64'd0) begin
         errors++; $display("FAIL async_rst count %0d valid %b imm %h exp 0 0 0", count, out_valid, out_imm); end
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      step(1, 32'h00700093, 1, 0, 0, 0);
      checks++; if (count !== 3'd1 || out_imm !== 32'd7) begin
         errors++; $display("FAIL after_rst count %0d imm %h exp 1 7", count, out_imm); end
   endtask

   initial begin
      test_reset();
      test_auto_formats();
      test_u64_manual();
      test_fill();
      test_random();
      test_flush();
      test_async_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
